// File: rtl/key_move_ctrl.sv
`default_nettype none
// ---- key_move_ctrl : 4-key sync/debounce, last-pressed arbitration, step pulse + auto-repeat ----
// ---- Rev 1.0 --------------------------------------------------------------------------------
module key_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 64,
  parameter int STEP_PERIOD     = 4
) (
  input  logic       clk_run,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       key_up_i,
  input  logic       key_down_i,
  input  logic       key_left_i,
  input  logic       key_right_i,
  output logic       move_en_o,
  output logic [1:0] direct_o,
  output logic       moving_o
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > STEP_PERIOD) ? REPEAT_DELAY : STEP_PERIOD;
  localparam int RCW  = $clog2(RMAX + 1);

  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] DELAY_LOAD = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] STEP_LOAD  = RCW'(STEP_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_e;

  // Bit index equals the direction code: 0=UP 1=DOWN 2=LEFT 3=RIGHT.
  logic [3:0] key_raw;
  logic [3:0] held_q;
  logic [3:0] held_d;
  logic [3:0] press;

  assign key_raw = {key_right_i, key_left_i, key_down_i, key_up_i};

  for (genvar i = 0; i < 4; i++) begin : g_key
    logic           s1_q;
    logic           s2_q;
    logic           deb_q;
    logic [DBW-1:0] cnt_q;
    logic           flip;

    assign flip = (s2_q != deb_q) && (cnt_q == DB_LAST);

    always_ff @(posedge clk_run or negedge rst_n) begin
      if (!rst_n) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        deb_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q <= key_raw[i];
        s2_q <= s1_q;
        if ((s2_q == deb_q) || flip) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + DBW'(1);
        end
        if (flip) begin
          deb_q <= s2_q;
        end
      end
    end

    assign held_q[i] = deb_q;
    // The FSM acts on the debounced value being registered this edge, so a
    // press is answered by a pulse in the very next cycle.
    assign held_d[i] = flip ? s2_q : deb_q;
  end

  assign press = held_d & ~held_q;

  function automatic logic [1:0] pick_dir(input logic [3:0] v);
    casez (v)
      4'b???1: return 2'b00;
      4'b??10: return 2'b01;
      4'b?100: return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  state_e         state_q;
  logic [RCW-1:0] rcnt_q;
  logic           move_en_q;
  logic [1:0]     dir_q;
  logic           moving_q;

  logic           restart;
  logic [1:0]     restart_dir;

  // A fresh press beats everything; otherwise entering from IDLE or losing the
  // active key falls back to the highest-priority key still held.
  always_comb begin
    restart     = 1'b0;
    restart_dir = pick_dir(held_d);
    if (|press) begin
      restart     = 1'b1;
      restart_dir = pick_dir(press);
    end else if ((state_q == S_IDLE) || !held_d[dir_q]) begin
      restart     = 1'b1;
    end
  end

  always_ff @(posedge clk_run or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rcnt_q    <= '0;
      move_en_q <= 1'b0;
      dir_q     <= 2'b00;
      moving_q  <= 1'b0;
    end else begin
      move_en_q <= 1'b0;
      moving_q  <= en_i & (|held_d);
      if (!en_i || (held_d == 4'b0000)) begin
        state_q <= S_IDLE;
        rcnt_q  <= '0;
      end else if (restart) begin
        move_en_q <= 1'b1;
        dir_q     <= restart_dir;
        state_q   <= S_DELAY;
        rcnt_q    <= DELAY_LOAD;
      end else if (rcnt_q == '0) begin
        move_en_q <= 1'b1;
        state_q   <= S_REPEAT;
        rcnt_q    <= STEP_LOAD;
      end else begin
        rcnt_q <= rcnt_q - RCW'(1);
      end
    end
  end

  assign move_en_o = move_en_q;
  assign direct_o  = dir_q;
  assign moving_o  = moving_q;

endmodule
`default_nettype wire

// File: tb/tb_key_move_ctrl.sv
`default_nettype none
// ---- tb_key_move_ctrl : directed bench for key_move_ctrl (DEBOUNCE=4, DELAY=10, STEP=3) ----
// ---- Rev 1.0 ------------------------------------------------------------------------------
module tb_key_move_ctrl;

  logic       clk_run = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en_i    = 1'b1;
  logic       key_up_i    = 1'b0;
  logic       key_down_i  = 1'b0;
  logic       key_left_i  = 1'b0;
  logic       key_right_i = 1'b0;
  logic       move_en_o;
  logic [1:0] direct_o;
  logic       moving_o;

  int n_vec = 0;
  int n_err = 0;

  key_move_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .STEP_PERIOD    (3)
  ) dut (
    .clk_run    (clk_run),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .key_up_i   (key_up_i),
    .key_down_i (key_down_i),
    .key_left_i (key_left_i),
    .key_right_i(key_right_i),
    .move_en_o  (move_en_o),
    .direct_o   (direct_o),
    .moving_o   (moving_o)
  );

  always #5 clk_run = ~clk_run;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk_run);
    #1;
  endtask

  // Edges until the next strobe; gives up at max_edges.
  task automatic wait_pulse(input int max_edges, output int lat);
    lat = 0;
    do begin
      tick1();
      lat++;
    end while (!move_en_o && lat < max_edges);
  endtask

  task automatic tick_count(input int n, output int np);
    np = 0;
    repeat (n) begin
      tick1();
      if (move_en_o) np++;
    end
  endtask

  int lat;
  int np;

  initial begin
    // Reset state
    tick1();
    tick1();
    chk_val("rst_move_en", move_en_o, 0);
    chk_val("rst_direct", direct_o, 0);
    chk_val("rst_moving", moving_o, 0);
    rst_n = 1'b1;
    tick_count(3, np);
    chk_val("idle_no_pulse", np, 0);

    // 1: single press of UP
    key_up_i = 1'b1;
    wait_pulse(40, lat);
    chk_val("up_first_lat", lat, 6);
    chk_val("up_first_dir", direct_o, 0);
    chk_val("up_moving", moving_o, 1);
    tick1();
    chk_val("up_pulse_width", move_en_o, 0);
    wait_pulse(40, lat);
    chk_val("up_delay_lat", lat, 9);
    wait_pulse(40, lat);
    chk_val("up_rep1_lat", lat, 3);
    wait_pulse(40, lat);
    chk_val("up_rep2_lat", lat, 3);
    chk_val("up_rep_dir", direct_o, 0);
    key_up_i = 1'b0;
    tick_count(7, np);
    chk_val("up_release_pulses", np, 1);
    chk_val("up_release_moving", moving_o, 0);

    // 2: bouncing LEFT is filtered out
    np = 0;
    for (int k = 0; k < 10; k++) begin
      int p;
      key_left_i = ~key_left_i;
      tick_count(2, p);
      np += p;
    end
    key_left_i = 1'b0;
    begin
      int p;
      tick_count(10, p);
      np += p;
    end
    chk_val("bounce_pulses", np, 0);
    chk_val("bounce_moving", moving_o, 0);

    // 3: last-pressed wins, fallback on release
    key_right_i = 1'b1;
    wait_pulse(40, lat);
    chk_val("right_first_lat", lat, 6);
    chk_val("right_first_dir", direct_o, 3);
    wait_pulse(40, lat);
    chk_val("right_delay_lat", lat, 10);
    wait_pulse(40, lat);
    chk_val("right_rep_lat", lat, 3);
    key_down_i = 1'b1;
    wait_pulse(40, lat);
    chk_val("right_rep2_lat", lat, 3);
    chk_val("right_rep2_dir", direct_o, 3);
    wait_pulse(40, lat);
    chk_val("down_press_lat", lat, 3);
    chk_val("down_press_dir", direct_o, 1);
    wait_pulse(40, lat);
    chk_val("down_delay_lat", lat, 10);
    chk_val("down_delay_dir", direct_o, 1);
    key_down_i = 1'b0;
    wait_pulse(40, lat);
    chk_val("down_rep_lat", lat, 3);
    chk_val("down_rep_dir", direct_o, 1);
    wait_pulse(40, lat);
    chk_val("fallback_right_lat", lat, 3);
    chk_val("fallback_right_dir", direct_o, 3);
    wait_pulse(40, lat);
    chk_val("fallback_delay_lat", lat, 10);
    key_right_i = 1'b0;
    tick_count(8, np);
    chk_val("right_release_moving", moving_o, 0);

    // 4: simultaneous UP+LEFT, then release UP
    key_up_i   = 1'b1;
    key_left_i = 1'b1;
    wait_pulse(40, lat);
    chk_val("simul_lat", lat, 6);
    chk_val("simul_dir", direct_o, 0);
    key_up_i = 1'b0;
    wait_pulse(40, lat);
    chk_val("simul_fallback_lat", lat, 6);
    chk_val("simul_fallback_dir", direct_o, 2);
    key_left_i = 1'b0;
    tick_count(8, np);
    chk_val("simul_release_moving", moving_o, 0);

    // 5: enable gating
    en_i       = 1'b0;
    key_down_i = 1'b1;
    tick_count(12, np);
    chk_val("dis_pulses", np, 0);
    chk_val("dis_moving", moving_o, 0);
    chk_val("dis_dir_hold", direct_o, 2);
    en_i = 1'b1;
    wait_pulse(40, lat);
    chk_val("en_rise_lat", lat, 1);
    chk_val("en_rise_dir", direct_o, 1);
    chk_val("en_rise_moving", moving_o, 1);
    en_i = 1'b0;
    tick1();
    chk_val("en_fall_moving", moving_o, 0);
    chk_val("en_fall_move_en", move_en_o, 0);
    en_i = 1'b1;
    wait_pulse(40, lat);
    chk_val("en_again_lat", lat, 1);

    // 6: asynchronous reset during REPEAT
    wait_pulse(40, lat);
    chk_val("pre_rst_delay_lat", lat, 10);
    wait_pulse(40, lat);
    chk_val("pre_rst_rep_lat", lat, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("async_rst_move_en", move_en_o, 0);
    chk_val("async_rst_dir", direct_o, 0);
    chk_val("async_rst_moving", moving_o, 0);
    tick1();
    tick1();
    rst_n = 1'b1;
    wait_pulse(40, lat);
    chk_val("post_rst_lat", lat, 6);
    chk_val("post_rst_dir", direct_o, 1);
    key_down_i = 1'b0;
    tick_count(8, np);
    chk_val("final_moving", moving_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
